// File: rtl/debug_dump_tx_pkg.sv
// Shared encodings for the debug dump transmitter: FSM states, frame sections,
// header byte and the frame-length helper used by host-side tooling.
package debug_dump_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEND_HDR,
        SEND,
        FETCH,
        WAIT,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        SEC_PC,
        SEC_REG,
        SEC_MEM
    } section_t;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    // Header byte plus PC, registers and memory words at 4 bytes each.
    function automatic int frame_len(input int num_regs, input int mem_words);
        return 1 + 4 * (1 + num_regs + mem_words);
    endfunction

endpackage

// File: rtl/debug_dump_tx_word_serializer.sv
// Holds one 32-bit word and emits it as 4 bytes MSB first, one byte per
// cycle the FIFO has room; word_done marks the strobe of the last byte.
module debug_dump_tx_word_serializer (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_word,
    input  logic        en,
    input  logic        tx_full,
    output logic [7:0]  tx_byte,
    output logic        wr,
    output logic        word_done
);

    logic [31:0] word_q;
    logic [1:0]  byte_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q   <= '0;
            byte_idx <= '0;
        end else if (load) begin
            word_q   <= load_word;
            byte_idx <= '0;
        end else if (wr) begin
            // Wraps back to 0 after the fourth byte.
            byte_idx <= byte_idx + 2'd1;
        end
    end

    always_comb begin
        tx_byte = word_q[31:24];
        case (byte_idx)
            2'd0: tx_byte = word_q[31:24];
            2'd1: tx_byte = word_q[23:16];
            2'd2: tx_byte = word_q[15:8];
            2'd3: tx_byte = word_q[7:0];
            default: tx_byte = word_q[31:24];
        endcase
    end

    assign wr        = en && !tx_full;
    assign word_done = wr && (byte_idx == 2'd3);

endmodule

// File: rtl/debug_dump_tx.sv
// Debug dump transmitter: on i_start streams header, PC, register file and
// data memory as bytes into the UART TX FIFO, respecting tx_full.
module debug_dump_tx
    import debug_dump_tx_pkg::*;
#(
    parameter int         SIZE          = 32,
    parameter int         NUM_REGISTERS = 32,
    parameter int         MEM_SIZE      = 64,
    parameter int         ADDR_WIDTH    = $clog2(MEM_SIZE),
    parameter logic [7:0] HEADER        = HEADER_BYTE
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [SIZE-1:0]       i_pc,
    output logic [4:0]            o_reg_addr,
    input  logic [SIZE-1:0]       i_reg_data,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic [SIZE-1:0]       i_mem_data,
    input  logic                  i_tx_full,
    output logic [7:0]            o_tx_data,
    output logic                  o_wr_uart,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int IDX_MAX = (NUM_REGISTERS > MEM_SIZE) ? NUM_REGISTERS : MEM_SIZE;
    localparam int IDX_W   = $clog2(IDX_MAX) + 1;

    state_t                state_q, state_d;
    section_t              section_q;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_nx;
    logic [4:0]            reg_addr_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;

    logic                  ser_load;
    logic [31:0]           ser_word;
    logic                  ser_en;
    logic [7:0]            ser_byte;
    logic                  ser_wr;
    logic                  word_done;

    logic                  last_reg;
    logic                  last_mem;
    logic                  frame_end;

    assign idx_nx    = idx_q + IDX_W'(1);
    assign last_reg  = (idx_q == IDX_W'(NUM_REGISTERS - 1));
    assign last_mem  = (idx_q == IDX_W'(MEM_SIZE - 1));
    assign frame_end = (section_q == SEC_MEM) && last_mem;

    debug_dump_tx_word_serializer u_ser (
        .clk       (i_clk),
        .rst       (i_rst),
        .load      (ser_load),
        .load_word (ser_word),
        .en        (ser_en),
        .tx_full   (i_tx_full),
        .tx_byte   (ser_byte),
        .wr        (ser_wr),
        .word_done (word_done)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        ser_load  = 1'b0;
        ser_word  = i_pc;
        ser_en    = 1'b0;
        o_wr_uart = 1'b0;
        o_tx_data = 8'h00;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    ser_load = 1'b1;
                    ser_word = i_pc;
                    state_d  = SEND_HDR;
                end
            end
            SEND_HDR: begin
                o_tx_data = HEADER;
                if (!i_tx_full) begin
                    o_wr_uart = 1'b1;
                    state_d   = SEND;
                end
            end
            SEND: begin
                ser_en    = 1'b1;
                o_tx_data = ser_byte;
                o_wr_uart = ser_wr;
                if (word_done) state_d = frame_end ? DONE : FETCH;
            end
            FETCH: state_d = WAIT;
            WAIT: begin
                // Read data lands one cycle after the address set on FETCH entry.
                ser_load = 1'b1;
                ser_word = (section_q == SEC_REG) ? i_reg_data : i_mem_data;
                state_d  = SEND;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign o_busy     = (state_q != IDLE) && (state_q != DONE);
    assign o_done     = (state_q == DONE);
    assign o_reg_addr = reg_addr_q;
    assign o_mem_addr = mem_addr_q;

    // Section walk; addresses change only when entering FETCH and hold otherwise.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            section_q  <= SEC_PC;
            idx_q      <= '0;
            reg_addr_q <= '0;
            mem_addr_q <= '0;
        end else if (state_q == IDLE && i_start) begin
            section_q <= SEC_PC;
            idx_q     <= '0;
        end else if (state_q == SEND && word_done && !frame_end) begin
            case (section_q)
                SEC_PC: begin
                    section_q  <= SEC_REG;
                    idx_q      <= '0;
                    reg_addr_q <= '0;
                end
                SEC_REG: begin
                    if (!last_reg) begin
                        idx_q      <= idx_nx;
                        reg_addr_q <= 5'(idx_nx);
                    end else begin
                        section_q  <= SEC_MEM;
                        idx_q      <= '0;
                        mem_addr_q <= '0;
                    end
                end
                SEC_MEM: begin
                    idx_q      <= idx_nx;
                    mem_addr_q <= ADDR_WIDTH'(idx_nx);
                end
                default: section_q <= SEC_PC;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_dump_tx.sv
// Directed bench for debug_dump_tx: default frame, backpressure, ignored
// restarts, mid-frame reset and a small-parameter instance.
module tb_debug_dump_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start2;
    logic [31:0] pc;
    logic        full;
    logic        full2 = 1'b0;

    logic [4:0]  reg_addr, reg_addr2;
    logic [5:0]  mem_addr;
    logic [0:0]  mem_addr2;
    logic [31:0] reg_data = '0, mem_data = '0, reg_data2 = '0, mem_data2 = '0;
    logic [7:0]  tx_data, tx_data2;
    logic        wr, wr2, busy, busy2, done, done2;

    int checks = 0;
    int failures = 0;

    logic [7:0] cap1[$];
    logic [7:0] cap2[$];
    int viol1 = 0, ndone1 = 0, nbusy1 = 0;
    int ndone2 = 0, nbusy2 = 0, max_mem2 = 0;

    always #5 clk = ~clk;

    debug_dump_tx u_dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_pc(pc),
        .o_reg_addr(reg_addr), .i_reg_data(reg_data),
        .o_mem_addr(mem_addr), .i_mem_data(mem_data),
        .i_tx_full(full), .o_tx_data(tx_data), .o_wr_uart(wr),
        .o_busy(busy), .o_done(done)
    );

    debug_dump_tx #(.NUM_REGISTERS(4), .MEM_SIZE(2)) u_dut_small (
        .i_clk(clk), .i_rst(rst), .i_start(start2), .i_pc(pc),
        .o_reg_addr(reg_addr2), .i_reg_data(reg_data2),
        .o_mem_addr(mem_addr2), .i_mem_data(mem_data2),
        .i_tx_full(full2), .o_tx_data(tx_data2), .o_wr_uart(wr2),
        .o_busy(busy2), .o_done(done2)
    );

    // Synchronous-read sources: data is valid one cycle after the address.
    always @(posedge clk) begin
        reg_data  <= 32'(reg_addr)  * 32'h01010101;
        mem_data  <= 32'hDEAD0000 + 32'(mem_addr);
        reg_data2 <= 32'(reg_addr2) * 32'h01010101;
        mem_data2 <= 32'hDEAD0000 + 32'(mem_addr2);
    end

    always @(negedge clk) begin
        if (wr) cap1.push_back(tx_data);
        if (wr && full) viol1++;
        if (done) ndone1++;
        if (busy) nbusy1++;
        if (wr2) cap2.push_back(tx_data2);
        if (done2) ndone2++;
        if (busy2) nbusy2++;
        if (int'(mem_addr2) > max_mem2) max_mem2 = int'(mem_addr2);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int nr, input int ms, input int k);
        logic [31:0] w;
        int wi, bi;
        if (k == 0) return 8'hA5;
        wi = (k - 1) / 4;
        bi = (k - 1) % 4;
        if (wi == 0)       w = 32'h00400010;
        else if (wi <= nr) w = 32'(wi - 1) * 32'h01010101;
        else               w = 32'hDEAD0000 + 32'(wi - 1 - nr);
        return w[31 - 8*bi -: 8];
    endfunction

    task automatic chk_frame(input string tag, input int sel, input int base,
                             input int nr, input int ms);
        int bad = 0;
        int len = 1 + 4 * (1 + nr + ms);
        int sz  = (sel == 1) ? cap1.size() : cap2.size();
        logic [7:0] b;
        for (int k = 0; k < len; k++) begin
            if (base + k >= sz) bad++;
            else begin
                b = (sel == 1) ? cap1[base + k] : cap2[base + k];
                if (b !== exp_byte(nr, ms, k)) bad++;
            end
        end
        chk({tag, "_bytes_bad"}, 32'(bad), 32'd0);
    endtask

    task automatic wait_done(input int sel, input int d0, input int bound, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(posedge clk); #1;
            if (((sel == 1) ? ndone1 : ndone2) > d0) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_bytes(input int base, input int n, input int bound, input string tag);
        logic seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (cap1.size() - base >= n) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk({tag, "_reached"}, 32'(seen), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] head13[13];
        logic [7:0] tail4[4];
        logic [7:0] tail4s[4];
        int b, d, nb;

        head13 = '{8'hA5, 8'h00, 8'h40, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00,
                   8'h01, 8'h01, 8'h01, 8'h01};
        tail4  = '{8'hDE, 8'hAD, 8'h00, 8'h3F};
        tail4s = '{8'hDE, 8'hAD, 8'h00, 8'h01};

        rst = 1'b1; start = 1'b0; start2 = 1'b0; full = 1'b0; pc = 32'h00400010;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_reg_addr", 32'(reg_addr), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Basic frame, FIFO never full
        b = cap1.size(); d = ndone1; nb = nbusy1;
        pulse_start();
        wait_done(1, d, 2000, "basic");
        repeat (2) @(posedge clk);
        #1;
        chk("basic_len", 32'(cap1.size() - b), 32'd389);
        for (int k = 0; k < 13; k++)
            chk($sformatf("basic_head%0d", k), 32'(cap1[b + k]), 32'(head13[k]));
        for (int k = 0; k < 4; k++)
            chk($sformatf("basic_tail%0d", k), 32'(cap1[b + 385 + k]), 32'(tail4[k]));
        chk_frame("basic", 1, b, 32, 64);
        chk("basic_done_pulses", 32'(ndone1 - d), 32'd1);
        chk("basic_busy_cycles", 32'(nbusy1 - nb), 32'd581);
        chk("basic_idle_busy", 32'(busy), 32'd0);

        // Backpressure: 7 full cycles at byte 2 of reg 5 (frame byte 27), then random
        b = cap1.size(); d = ndone1;
        pulse_start();
        wait_bytes(b, 27, 200, "bp_pos");
        full = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        chk("bp_hold_count", 32'(cap1.size() - b), 32'd27);
        for (int i = 0; i < 6000; i++) begin
            if (ndone1 > d) break;
            full = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        full = 1'b0;
        wait_done(1, d, 50, "bp");
        chk("bp_len", 32'(cap1.size() - b), 32'd389);
        chk_frame("bp", 1, b, 32, 64);
        chk("bp_strobe_while_full", 32'(viol1), 32'd0);

        // Restart ignored mid-frame and in the DONE cycle
        b = cap1.size(); d = ndone1;
        pulse_start();
        wait_bytes(b, 50, 200, "rs_mid");
        pulse_start();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            if (done) begin
                pulse_start();
                break;
            end
        end
        repeat (20) @(posedge clk);
        #1;
        chk("rs_idle_busy", 32'(busy), 32'd0);
        chk("rs_len", 32'(cap1.size() - b), 32'd389);
        chk("rs_done_pulses", 32'(ndone1 - d), 32'd1);
        chk_frame("rs", 1, b, 32, 64);
        b = cap1.size(); d = ndone1;
        pulse_start();
        wait_done(1, d, 2000, "rs2");
        #20;
        chk("rs2_len", 32'(cap1.size() - b), 32'd389);
        chk_frame("rs2", 1, b, 32, 64);

        // Reset mid-frame at byte 100
        b = cap1.size();
        pulse_start();
        wait_bytes(b, 100, 400, "mr_pos");
        chk("mr_pre_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mr_wr", 32'(wr), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_tx_data", 32'(tx_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mr_partial_len", 32'(cap1.size() - b), 32'd100);
        b = cap1.size(); d = ndone1;
        pulse_start();
        wait_done(1, d, 2000, "mr");
        #20;
        chk("mr_len", 32'(cap1.size() - b), 32'd389);
        chk("mr_first", 32'(cap1[b]), 32'hA5);
        chk_frame("mr", 1, b, 32, 64);

        // Small instance: 4 registers, 2 memory words
        b = cap2.size(); d = ndone2; nb = nbusy2;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        wait_done(2, d, 500, "sw");
        #20;
        chk("sw_len", 32'(cap2.size() - b), 32'd29);
        for (int k = 0; k < 4; k++)
            chk($sformatf("sw_tail%0d", k), 32'(cap2[b + 25 + k]), 32'(tail4s[k]));
        chk_frame("sw", 2, b, 4, 2);
        chk("sw_busy_cycles", 32'(nbusy2 - nb), 32'd41);
        chk("sw_max_mem_addr", 32'(max_mem2), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
